// File: rtl/pipelined_cla_adder.sv
// Pipelined radix-4 carry-lookahead adder/subtractor with N/Z/C/V flags.
// One lookahead tree level is registered per stage; the result is registered LEVELS+1 cycles after acceptance.
module pipelined_cla_adder #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             neg,
    output logic             zero
);

    function automatic int unsigned log4(input int unsigned w);
        int unsigned n;
        n = 0;
        for (int unsigned v = w; v > 1; v = v >> 2) n++;
        return n;
    endfunction

    localparam int unsigned LEVELS  = log4(WIDTH);
    localparam int unsigned LATENCY = LEVELS + 1;
    localparam int unsigned TOP     = LEVELS - 1;

    // lp/lg[s][l]: group propagate/generate of tree level l as held in stage s (valid for l <= s).
    // Bits above the populated group count stay zero, so grouping them yields zero.
    logic [WIDTH-1:0]   lp [LEVELS][LEVELS];
    logic [WIDTH-1:0]   lg [LEVELS][LEVELS];
    logic [LEVELS-1:0]  c0_r;
    logic [LEVELS-1:0]  a_msb;
    logic [LEVELS-1:0]  b_msb;
    logic [LATENCY-1:0] vld;

    logic               stall;
    logic [WIDTH-1:0]   b_eff;
    logic               c0_in;
    logic [WIDTH-1:0]   sum_next;
    logic               cout_next;
    logic               ovf_next;

    function automatic logic [WIDTH-1:0] group_p(input logic [WIDTH-1:0] p);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < WIDTH / 4; i++)
            r[i] = &p[4*i +: 4];
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] group_g(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < WIDTH / 4; i++)
            r[i] = g[4*i+3]
                 | (g[4*i+2] & p[4*i+3])
                 | (g[4*i+1] & p[4*i+2] & p[4*i+3])
                 | (g[4*i]   & p[4*i+1] & p[4*i+2] & p[4*i+3]);
        return r;
    endfunction

    assign stall     = vld[LATENCY-1] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = vld[LATENCY-1];

    always_comb begin
        b_eff = op[1] ? ~b : b;
        case (op)
            2'b00:   c0_in = 1'b0;
            2'b10:   c0_in = 1'b1;
            default: c0_in = cin;
        endcase
    end

    // Carries resolve top-down: each group's first element inherits its parent's carry-in,
    // the rest ripple from siblings inside the 4-wide group.
    always_comb begin
        logic [WIDTH-1:0] carry [LEVELS];
        for (int unsigned l = 0; l < LEVELS; l++) carry[l] = '0;
        carry[TOP][0] = c0_r[TOP];
        for (int unsigned j = 1; j < 4; j++)
            carry[TOP][j] = lg[TOP][TOP][j-1] | (lp[TOP][TOP][j-1] & carry[TOP][j-1]);
        cout_next = lg[TOP][TOP][3] | (lp[TOP][TOP][3] & carry[TOP][3]);
        for (int unsigned k = 1; k < LEVELS; k++) begin
            carry[TOP-k][0] = carry[TOP-k+1][0];
            for (int unsigned i = 1; i < WIDTH; i++)
                carry[TOP-k][i] = (i % 4 == 0) ? carry[TOP-k+1][i/4]
                                : (lg[TOP][TOP-k][i-1] | (lp[TOP][TOP-k][i-1] & carry[TOP-k][i-1]));
        end
        sum_next = lp[TOP][0] ^ carry[0];
        ovf_next = (a_msb[TOP] == b_msb[TOP]) && (sum_next[WIDTH-1] != a_msb[TOP]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld   <= '0;
            c0_r  <= '0;
            a_msb <= '0;
            b_msb <= '0;
            for (int unsigned s = 0; s < LEVELS; s++)
                for (int unsigned l = 0; l < LEVELS; l++) begin
                    lp[s][l] <= '0;
                    lg[s][l] <= '0;
                end
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            neg  <= 1'b0;
            zero <= 1'b0;
        end else if (!stall) begin
            vld <= {vld[LATENCY-2:0], in_valid};

            lp[0][0] <= a ^ b_eff;
            lg[0][0] <= a & b_eff;
            c0_r[0]  <= c0_in;
            a_msb[0] <= a[WIDTH-1];
            b_msb[0] <= b_eff[WIDTH-1];

            for (int unsigned s = 1; s < LEVELS; s++) begin
                for (int unsigned l = 0; l < s; l++) begin
                    lp[s][l] <= lp[s-1][l];
                    lg[s][l] <= lg[s-1][l];
                end
                lp[s][s] <= group_p(lp[s-1][s-1]);
                lg[s][s] <= group_g(lp[s-1][s-1], lg[s-1][s-1]);
                c0_r[s]  <= c0_r[s-1];
                a_msb[s] <= a_msb[s-1];
                b_msb[s] <= b_msb[s-1];
            end

            if (vld[TOP]) begin
                sum  <= sum_next;
                cout <= cout_next;
                ovf  <= ovf_next;
                neg  <= sum_next[WIDTH-1];
                zero <= (sum_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: a 4-bit instance (exhaustive) and a 64-bit instance
// (directed, backpressure, bubbles, reset, random) checked against an arithmetic reference model.
module tb_pipelined_cla_adder;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        neg;
        logic        zero;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  iv = 2'b00;
    logic [1:0]  ordy = 2'b11;
    logic [63:0] ia [2];
    logic [63:0] ib [2];
    logic [1:0]  iop [2];
    logic [1:0]  icin = 2'b00;

    logic        rdy4, vld4, c4, v4, n4, z4;
    logic        rdy64, vld64, c64, v64, n64, z64;
    logic [3:0]  s4;
    logic [63:0] s64;
    logic [1:0]  irdy, ovld;
    res_t        outr [2];

    assign irdy    = {rdy64, rdy4};
    assign ovld    = {vld64, vld4};
    assign outr[0] = {60'b0, s4, c4, v4, n4, z4};
    assign outr[1] = {s64, c64, v64, n64, z64};

    pipelined_cla_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(rdy4),
        .a(ia[0][3:0]), .b(ib[0][3:0]), .cin(icin[0]), .op(iop[0]),
        .out_valid(vld4), .out_ready(ordy[0]), .sum(s4),
        .cout(c4), .ovf(v4), .neg(n4), .zero(z4)
    );

    pipelined_cla_adder #(.WIDTH(64)) u_dut64 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(rdy64),
        .a(ia[1]), .b(ib[1]), .cin(icin[1]), .op(iop[1]),
        .out_valid(vld64), .out_ready(ordy[1]), .sum(s64),
        .cout(c64), .ovf(v64), .neg(n64), .zero(z64)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    res_t        q0 [$];
    res_t        q1 [$];
    logic [7:0]  hist [2];
    int unsigned run [2];
    logic [1:0]  pstall = 2'b00;
    res_t        pout [2];
    logic        rnd_done = 1'b0;

    function automatic int unsigned lat(input int unsigned k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic int unsigned qsize(input int unsigned k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic res_t qpop(input int unsigned k);
        if (k == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // Reference: plain modular and signed arithmetic on a + b_eff + c0.
    function automatic res_t model(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                                   input logic [1:0] op, input logic ci);
        logic [64:0]        m, tot;
        logic [63:0]        be;
        logic               c0;
        logic signed [66:0] sa, sb, ex, hi, lo;
        res_t               r;
        m   = (65'd1 << w) - 65'd1;
        be  = op[1] ? (~b & m[63:0]) : b;
        c0  = (op == 2'b00) ? 1'b0 : (op == 2'b10) ? 1'b1 : ci;
        tot = {1'b0, a} + {1'b0, be} + {64'b0, c0};
        r.sum  = tot[63:0] & m[63:0];
        r.cout = tot[w];
        sa = a[w-1]  ? $signed({3'b0, a})  - $signed(67'd1 << w) : $signed({3'b0, a});
        sb = be[w-1] ? $signed({3'b0, be}) - $signed(67'd1 << w) : $signed({3'b0, be});
        ex = sa + sb + $signed({66'b0, c0});
        hi = $signed(67'd1 << (w - 1)) - 67'sd1;
        lo = -$signed(67'd1 << (w - 1));
        r.ovf  = (ex > hi) || (ex < lo);
        r.neg  = r.sum[w-1];
        r.zero = (r.sum == 64'd0);
        return r;
    endfunction

    task automatic chk(input string name, input int unsigned k, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Monitor: protocol rules, hold-under-stall, bubble timing and in-order scoreboard.
    always @(negedge clk) begin
        for (int unsigned k = 0; k < 2; k++) begin
            if (reset) begin
                hist[k]   = '0;
                run[k]    = 0;
                pstall[k] = 1'b0;
            end else begin
                chk("in_ready", k, 72'(irdy[k]), 72'(!(ovld[k] && !ordy[k])));
                if (pstall[k])
                    chk("stall_hold", k, 72'({ovld[k], outr[k]}), 72'({1'b1, pout[k]}));
                if (run[k] >= lat(k))
                    chk("valid_timing", k, 72'(ovld[k]), 72'(hist[k][lat(k)-1]));
                if (ovld[k] && ordy[k]) begin
                    if (qsize(k) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output[%0d] got %h expected none", k, outr[k]);
                    end else begin
                        chk("result", k, 72'(outr[k]), 72'(qpop(k)));
                    end
                end
                pstall[k] = ovld[k] && !ordy[k];
                pout[k]   = outr[k];
                hist[k]   = {hist[k][6:0], iv[k] && irdy[k]};
                run[k]    = ordy[k] ? ((run[k] < 100) ? run[k] + 1 : run[k]) : 0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after acceptance.
    task automatic send(input int unsigned k, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] op, input logic ci, input res_t e);
        int unsigned n;
        n = 0;
        ia[k] = a; ib[k] = b; iop[k] = op; icin[k] = ci; iv[k] = 1'b1;
        forever begin
            @(negedge clk);
            if (irdy[k]) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout[%0d] got in_ready=0 expected 1 within 100 cycles", k);
                break;
            end
        end
        if (n <= 100) begin
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk); #1;
        iv[k]   = 1'b0;
        ia[k]   = {$urandom, $urandom};
        ib[k]   = {$urandom, $urandom};
        iop[k]  = 2'($urandom);
        icin[k] = 1'($urandom);
    endtask

    task automatic send_rand(input int unsigned k);
        logic [63:0] a, b;
        logic [1:0]  op;
        logic        ci;
        int unsigned w;
        w  = (k == 0) ? 4 : 64;
        a  = {$urandom, $urandom};
        b  = {$urandom, $urandom};
        if (k == 0) begin
            a = a & 64'hF;
            b = b & 64'hF;
        end
        op = 2'($urandom);
        ci = 1'($urandom);
        send(k, a, b, op, ci, model(w, a, b, op, ci));
    endtask

    task automatic idle(input int unsigned k, input int unsigned n);
        iv[k] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int unsigned k);
        int unsigned n;
        n = 0;
        while (qsize(k) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", k, 72'(qsize(k)), 72'(0));
        @(posedge clk); #1;
    endtask

    task automatic mid_reset();
        #2 reset = 1'b1;
        q0.delete();
        q1.delete();
        #1;
        for (int unsigned k = 0; k < 2; k++)
            chk("reset_outputs", k, 72'({ovld[k], outr[k]}), 72'(0));
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk("ready_after_reset", 0, 72'(irdy), 72'(2'b11));
        @(posedge clk); #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [4:0] pat;
        for (int unsigned k = 0; k < 2; k++) begin
            ia[k] = '0; ib[k] = '0; iop[k] = '0;
        end
        #1 reset = 1'b1;
        #2;
        for (int unsigned k = 0; k < 2; k++)
            chk("reset_state", k, 72'({ovld[k], outr[k]}), 72'(0));
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1 chk("ready_out_of_reset", 0, 72'(irdy), 72'(2'b11));
        @(posedge clk); #1;

        // Exhaustive 4-bit sweep, continuous stream
        for (int unsigned a = 0; a < 16; a++)
            for (int unsigned b = 0; b < 16; b++)
                for (int unsigned o = 0; o < 4; o++)
                    for (int unsigned c = 0; c < 2; c++)
                        send(0, 64'(a), 64'(b), 2'(o), 1'(c), model(4, 64'(a), 64'(b), 2'(o), 1'(c)));
        drain(0);

        // Directed 64-bit corners with literal expectations
        send(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b0, {64'h0, 1'b1, 1'b0, 1'b0, 1'b1});
        send(1, 64'h8000_0000_0000_0000, 64'd1, 2'b10, 1'b0,
             {64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0});
        send(1, 64'd5, 64'd5, 2'b11, 1'b0, {64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0});
        drain(1);

        // Backpressure: 8 back-to-back, 5-cycle stall after first out_valid
        fork
            begin
                for (int unsigned i = 0; i < 8; i++) send_rand(1);
            end
            begin
                int unsigned w;
                w = 0;
                while (!ovld[1] && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                chk("first_valid_seen", 1, 72'(ovld[1]), 72'(1));
                @(posedge clk); #1;
                ordy[1] = 1'b0;
                repeat (5) @(posedge clk);
                #1 ordy[1] = 1'b1;
            end
        join
        drain(1);

        // Bubbles 1,0,1,1,0 on both widths
        pat = 5'b01101;
        for (int unsigned i = 0; i < 5; i++)
            if (pat[i]) begin
                fork
                    send_rand(0);
                    send_rand(1);
                join
            end else begin
                fork
                    idle(0, 1);
                    idle(1, 1);
                join
            end
        drain(0);
        drain(1);

        // Asynchronous reset with 3 ops in flight, then a fresh op
        fork
            for (int unsigned i = 0; i < 3; i++) send_rand(0);
            for (int unsigned i = 0; i < 3; i++) send_rand(1);
        join
        mid_reset();
        repeat (6) @(posedge clk);
        #1;
        send_rand(0);
        send_rand(1);
        drain(0);
        drain(1);

        // Random traffic with random out_ready and bubbles
        fork
            begin
                for (int unsigned i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) idle(1, 1);
                    else                          send_rand(1);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    ordy[1] = ($urandom_range(0, 2) != 0);
                end
                ordy[1] = 1'b1;
            end
        join
        drain(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath.
- Built as a radix-4 tree of 4-bit lookahead carry units.
- Registers one tree level per pipeline stage, so wide adds close timing at CPU clock rate.
- Uses a valid/ready handshake with full backpressure.
- Produces the sum plus N/Z/C/V flags for the ALU flag register.

Parameters:
- WIDTH, 64, operand width; legal values 4, 16, 64 (a power of 4).
- LEVELS, log4(WIDTH), number of lookahead tree levels; derived, not overridden.
- LATENCY, LEVELS+1, cycles from input acceptance to out_valid; derived.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used by op 01 and op 11 only.
- op  input  2  00 add, 01 add-with-carry, 10 subtract (a-b), 11 subtract-with-borrow (a+~b+cin).
- out_valid  output  1  result fields are valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1 (C flag; 1 means no borrow on subtract).
- ovf  output  1  signed overflow (V).
- neg  output  1  sum[WIDTH-1] (N).
- zero  output  1  sum == 0 (Z).

Behaviour:
- Operand preparation is combinational at the input: b_eff = op[1] ? ~b : b; c0 = op==00 ? 0 : op==10 ? 1 : cin.
- Stage 0 registers:
  - bitwise p = a ^ b_eff and g = a & b_eff;
  - a copy of p for the final XOR;
  - c0;
  - the sign bits of a and b_eff, for overflow.
- Stages 1..LEVELS-1 each register one tree level.
  - Each 4-input group unit computes group P = p0p1p2p3 and group G = g3 + g2p3 + g1p2p3 + g0p1p2p3.
  - Tree levels go upward; carries are resolved downward.
  - The implementation may resolve the carry distribution in any registered stages, but the total latency must be exactly LATENCY.
- The final stage registers sum = p ^ carries, plus cout, ovf, neg and zero.
  - ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb).
- Pipeline advance: stall = out_valid && !out_ready.
  - When stall is high, every stage holds, including valid bits and data.
  - in_ready = !stall, combinational.
- Transfer rules:
  - An input is accepted when in_valid && in_ready.
  - An output is consumed when out_valid && out_ready.
- Throughput: one operation per cycle when out_ready is held high. Results emerge in order with no bubbles inserted by the block.
- Per-stage valid bits propagate with the data. Bubbles, i.e. cycles with in_valid low, propagate as invalid stages. Bubbles are not collapsed during a stall; the stall is global.
- While out_valid is high and out_ready is low, all outputs stay stable until the handshake completes.
- Reset:
  - All stage valid bits clear immediately, asynchronously.
  - out_valid=0, sum=0, cout=0, ovf=0, neg=0, zero=0.
  - in_ready=1 once reset is deasserted.
  - In-flight operations are discarded; no partial result is ever emitted.
- Width rules:
  - No sign extension is performed.
  - cin and op are ignored when in_valid is low.
  - For WIDTH=4, LEVELS=1 and LATENCY=2.

Test Plan:
1. WIDTH=4 exhaustive (tb default): sweep all a, b, op, cin with out_ready=1 and in_valid continuous.
   - Required: each result, LATENCY cycles later, equals the reference model (sum, cout, ovf, neg, zero).
   - Required: one result per cycle, in order.
2. WIDTH=64, op=00, a=64'hFFFF_FFFF_FFFF_FFFF, b=1.
   - Required after 4 cycles: sum=0, cout=1, zero=1, ovf=0, neg=0.
   - This exercises full-width carry propagation through every level.
3. WIDTH=64, op=10, a=64'h8000_0000_0000_0000, b=1.
   - Required: sum=64'h7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1, neg=0.
   - Then op=11, cin=0, a=5, b=5. Required: sum=64'hFFFF_FFFF_FFFF_FFFF, cout=0, neg=1.
4. Backpressure: stream 8 ops back-to-back, hold out_ready=0 for 5 cycles after the first out_valid, then release.
   - Required: in_ready=0 during the stall and sum/flags stable.
   - Required: all 8 results delivered exactly once, in order.
5. Bubbles: toggle in_valid 1,0,1,1,0 with out_ready=1.
   - Required: the out_valid pattern equals the input pattern delayed by LATENCY.
6. Reset mid-operation: assert reset asynchronously, between clock edges, with 3 ops in flight.
   - Required: out_valid drops immediately and all outputs read 0.
   - Required: no stale result appears after reset is released.
   - Required: the first op accepted after reset returns correctly after LATENCY cycles.
